embertrail_issue_seq: RTL
=========================

EMBERTRAIL_ISSUE_SEQ -- requirements
Module: embertrail_issue_seq

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter and instruction-address width in 16-bit words.
REQ-002 SHALL have parameter MAX_ISSUE, default 2, maximum 16-bit instruction slots per bundle; legal range 1..4.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 1..16.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 iClock  in  1  sole clock; all state changes on its rising edge.
REQ-007 iReset  in  1  asynchronous active-low reset.
REQ-008 iValid  in  1  the current bundle at oInstAddrBus is decoded and consumed this cycle.
REQ-009 iIssueCount  in  3  16-bit words consumed by the current bundle.
REQ-010 iStall  in  1  holds the PC and all state; no bundle is consumed.
REQ-011 iBranchTaken  in  1  the current bundle resolves a taken branch or call.
REQ-012 iBranchTarget  in  PC_W  target address for the taken branch or call.
REQ-013 iCall  in  1  qualifies iBranchTaken as a call; pushes the return address.
REQ-014 iRet  in  1  the current bundle returns; pops the top of the return-address stack.
REQ-015 oInstAddrBus  out  PC_W  current fetch address (the PC register).
REQ-016 oFetchValid  out  1  the word at oInstAddrBus is valid to issue.
REQ-017 oRasEmpty / oRasFull  out  1 each  return-address-stack occupancy flags.
REQ-018 oRasErr  out  1  sticky flag for stack overflow or underflow; cleared only by reset.
REQ-019 oState  out  2  FSM state encoding: BOOT=0, RUN=1, STALL=2, REDIRECT=3.

Function
REQ-020 Effective count SHALL be computed as follows: iIssueCount=0 is treated as 1; values above MAX_ISSUE saturate to MAX_ISSUE.
REQ-021 Sequential next PC SHALL be PC + effective count, modulo 2^PC_W; 0xFFFF+2 gives 0x0001.
REQ-022 BOOT SHALL be entered on reset and last exactly one cycle after reset release, with oFetchValid=0 and the PC held; the FSM then goes to RUN.
REQ-023 RUN SHALL assert oFetchValid=1; a bundle is consumed only when iValid=1 and iStall=0.
REQ-024 RUN with iValid=0 and iStall=0: the PC SHALL hold and the FSM stays in RUN.
REQ-025 Event priority in RUN and STALL SHALL be iStall > iRet > iBranchTaken > sequential; lower-priority inputs in the same cycle are ignored.
REQ-026 iStall=1 SHALL move the FSM to STALL (or keep it there) and hold the PC and the stack; oFetchValid=1. When iStall=0, events are processed as in RUN.
REQ-027 A taken branch (iBranchTaken=1, iCall=0) SHALL load iBranchTarget into the PC next cycle and enter REDIRECT.
REQ-028 A call SHALL push the sequential next PC and load iBranchTarget into the PC next cycle, then enter REDIRECT.
REQ-029 A call with the stack full SHALL still take the branch; the push is dropped and oRasErr is set.
REQ-030 A return (iRet=1) with a non-empty stack SHALL pop the top entry into the PC and enter REDIRECT.
REQ-031 A return with an empty stack SHALL follow the sequential next PC, set oRasErr and stay in RUN.
REQ-032 REDIRECT SHALL last exactly one cycle with oFetchValid=0 (one bubble) and ignore all event inputs except iStall; iStall=1 extends REDIRECT with the PC held.
REQ-033 The stack SHALL be LIFO with RAS_DEPTH entries; oRasEmpty reflects count=0 and oRasFull reflects count=RAS_DEPTH, both registered with the state.
REQ-034 iCall or iRet while iValid=0 SHALL be ignored.

Reset
REQ-035 Reset assertion SHALL asynchronously set PC=RESET_PC, oState=BOOT, oFetchValid=0, stack count=0 (oRasEmpty=1, oRasFull=0) and oRasErr=0, including mid-REDIRECT or mid-STALL.
REQ-036 Reset release SHALL be sampled synchronously; the first RUN cycle follows exactly one BOOT cycle.

Verification
REQ-037 Reset, then iValid=1 and iIssueCount=2 for 3 cycles -> oInstAddrBus sequence is 0, 0, 2, 4, 6 (BOOT, then RUN); oFetchValid goes 0 then 1.
REQ-038 At PC=0x0010, call to 0x0100 with iIssueCount=1 -> PC=0x0100, one bubble; a later iRet -> PC=0x0011, one bubble, oRasEmpty=1.
REQ-039 With RAS_DEPTH=4, five nested calls -> oRasFull=1 after the 4th, oRasErr=1 after the 5th, and all branches are taken.
REQ-040 iRet with an empty stack at PC=0x0020 and iIssueCount=2 -> PC=0x0022, oRasErr=1, no bubble.
REQ-041 iStall=1 together with iBranchTaken=1 for 2 cycles, then released with iBranchTaken=1 -> PC holds 2 cycles, then the redirect occurs; iIssueCount=0 or 7 advances the PC by 1 or MAX_ISSUE.
REQ-042 Asserting iReset=0 during REDIRECT, and separately PC=0xFFFF with iIssueCount=2 -> immediate return to RESET_PC/BOOT; the wrap case gives PC=0x0001.

Source files
------------

// File: rtl/embertrail_issue_seq.sv
// Instruction-issue sequencer: PC advance by bundle size, branch/call/return redirects,
// a small return-address stack, and a BOOT/RUN/STALL/REDIRECT control FSM.
module embertrail_issue_seq #(
    parameter int              PC_W      = 16,
    parameter int              MAX_ISSUE = 2,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iValid,
    input  logic [2:0]      iIssueCount,
    input  logic            iStall,
    input  logic            iBranchTaken,
    input  logic [PC_W-1:0] iBranchTarget,
    input  logic            iCall,
    input  logic            iRet,
    output logic [PC_W-1:0] oInstAddrBus,
    output logic            oFetchValid,
    output logic            oRasEmpty,
    output logic            oRasFull,
    output logic            oRasErr,
    output logic [1:0]      oState
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    // A zero-word bundle still advances by one; oversize bundles clamp to the issue width.
    function automatic logic [2:0] eff_count(input logic [2:0] cnt);
        if (cnt == 3'd0) begin
            return 3'd1;
        end
        if (cnt > 3'(MAX_ISSUE)) begin
            return 3'(MAX_ISSUE);
        end
        return cnt;
    endfunction

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic             fetch_vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ras_empty_q;
    logic             ras_full_q;
    logic             ras_err_q;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    logic [PC_W-1:0]  seq_pc;
    logic             ev_take;
    logic             do_ret;
    logic             do_branch;
    logic             do_pop;
    logic             do_push;
    logic             ras_fault;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;

    always_comb begin
        seq_pc    = pc_q + PC_W'(eff_count(iIssueCount));
        ev_take   = ((state_q == ST_RUN) || (state_q == ST_STALL)) && !iStall && iValid;
        do_ret    = ev_take && iRet;
        do_branch = ev_take && !iRet && iBranchTaken;
        do_pop    = do_ret && !ras_empty_q;
        do_push   = do_branch && iCall && !ras_full_q;
        ras_fault = (do_ret && ras_empty_q) || (do_branch && iCall && ras_full_q);
        top_idx   = IDX_W'(cnt_q - CNT_W'(1));
        push_idx  = IDX_W'(cnt_q);
        cnt_d     = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            fetch_vld_q <= 1'b0;
            cnt_q       <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
            ras_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ras_empty_q <= (cnt_d == '0);
            ras_full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
            if (ras_fault) begin
                ras_err_q <= 1'b1;
            end
            case (state_q)
                ST_BOOT: begin
                    state_q     <= ST_RUN;
                    fetch_vld_q <= 1'b1;
                end
                ST_RUN, ST_STALL: begin
                    if (iStall) begin
                        state_q     <= ST_STALL;
                        fetch_vld_q <= 1'b1;
                    end else if (do_pop) begin
                        pc_q        <= ras_q[top_idx];
                        state_q     <= ST_REDIR;
                        fetch_vld_q <= 1'b0;
                    end else if (do_branch) begin
                        pc_q        <= iBranchTarget;
                        state_q     <= ST_REDIR;
                        fetch_vld_q <= 1'b0;
                    end else begin
                        // Covers sequential issue, empty-stack returns and idle cycles.
                        if (ev_take) begin
                            pc_q <= seq_pc;
                        end
                        state_q     <= ST_RUN;
                        fetch_vld_q <= 1'b1;
                    end
                end
                ST_REDIR: begin
                    if (iStall) begin
                        state_q     <= ST_REDIR;
                        fetch_vld_q <= 1'b0;
                    end else begin
                        state_q     <= ST_RUN;
                        fetch_vld_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_BOOT;
                    fetch_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Stack entries carry no reset; only the occupancy count defines what is live.
    always_ff @(posedge iClock) begin
        if (do_push) begin
            ras_q[push_idx] <= seq_pc;
        end
    end

    assign oInstAddrBus = pc_q;
    assign oFetchValid  = fetch_vld_q;
    assign oRasEmpty    = ras_empty_q;
    assign oRasFull     = ras_full_q;
    assign oRasErr      = ras_err_q;
    assign oState       = state_q;

endmodule
